// File: rtl/wfg_record_spi_pkg.sv
// wfg_record_spi shared types and constants.
// Receiver FSM state encoding and word/counter widths.
package wfg_record_spi_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int CNT_WIDTH  = 6;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PUSH,
    WAIT_CS
  } state_t;

endpackage

// File: rtl/wfg_record_spi_fifo.sv
// wfg_record_spi_fifo: synchronous first-word fall-through FIFO.
// Ports: push_i/wdata_i write, pop_i read, flush_i empties,
//   rdata_o is the head entry, full_o/empty_o status.
module wfg_record_spi_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_pop;
  logic             w_push;

  assign empty_o = (r_wr == r_rd);
  assign full_o  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign rdata_o = r_mem[r_rd[AW-1:0]];

  // When full, a simultaneous pop frees the slot being written.
  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush_i)
      r_mem[r_wr[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/wfg_record_spi.sv
// wfg_record_spi: SPI mode-0 subordinate receiver with FWFT FIFO.
// Ports: sclk_i/cs_i/sdi_i async pins; en_i, cs_pol_i, lsb_first_i,
//   dwidth_i config; rec_data_o/rec_valid_o/rec_ready_i stream;
//   overflow_o/frame_err_o sticky flags cleared by clr_i.
//   WFG_RECORD_SPI_STATS_EN adds frame_cnt_o and drop_cnt_o.
module wfg_record_spi
  import wfg_record_spi_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  cs_pol_i,
  input  logic                  lsb_first_i,
  input  logic [4:0]            dwidth_i,
  input  logic                  sclk_i,
  input  logic                  cs_i,
  input  logic                  sdi_i,
  output logic [WORD_WIDTH-1:0] rec_data_o,
  output logic                  rec_valid_o,
  input  logic                  rec_ready_i,
  output logic                  overflow_o,
  output logic                  frame_err_o,
  input  logic                  clr_i
`ifdef WFG_RECORD_SPI_STATS_EN
  ,
  output logic [15:0]           frame_cnt_o,
  output logic [7:0]            drop_cnt_o
`endif
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;
  state_t                 r_state;
  state_t                 w_next;
  logic [WORD_WIDTH-1:0]  r_shreg;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [4:0]             r_dwidth;
  logic                   r_lsb;
  logic                   r_cs_pol;
  logic                   r_ovf;
  logic                   r_ferr;

  logic w_sclk_s, w_cs_s, w_sdi_s;
  logic w_sclk_rise, w_cs_rise, w_cs_act_frm;
  logic w_start, w_shift, w_ferr, w_push_cyc;
  logic w_last;
  logic w_full, w_empty, w_pop, w_accept;
  logic w_fifo_push, w_drop;
  logic [WORD_WIDTH-1:0] w_head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_sdi_sync  <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_i};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], sdi_i};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;

  // Idle uses the live polarity; a frame uses the latched one.
  assign w_cs_rise    = (w_cs_s ^ ~cs_pol_i) &
                        ~(r_cs_prev ^ ~cs_pol_i);
  assign w_cs_act_frm = w_cs_s ^ ~r_cs_pol;
  assign w_last       = (r_cnt == {1'b0, r_dwidth});

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!en_i) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_cs_rise) w_next = SHIFT;
        SHIFT: begin
          if (!w_cs_act_frm)
            w_next = IDLE;
          else if (w_sclk_rise && w_last)
            w_next = PUSH;
        end
        PUSH:    w_next = WAIT_CS;
        WAIT_CS: if (!w_cs_act_frm) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_start    = 1'b0;
    w_shift    = 1'b0;
    w_ferr     = 1'b0;
    w_push_cyc = 1'b0;
    if (en_i) begin
      unique case (r_state)
        IDLE:  w_start = w_cs_rise;
        SHIFT: begin
          w_ferr  = ~w_cs_act_frm;
          w_shift = w_cs_act_frm & w_sclk_rise;
        end
        PUSH:  w_push_cyc = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_dwidth <= '0;
      r_lsb    <= 1'b0;
      r_cs_pol <= 1'b0;
    end else if (w_start) begin
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_dwidth <= dwidth_i;
      r_lsb    <= lsb_first_i;
      r_cs_pol <= cs_pol_i;
    end else if (w_shift) begin
      r_cnt <= r_cnt + 1'b1;
      // LSB-first enters at the word's top bit and walks down.
      if (r_lsb)
        r_shreg <= (r_shreg >> 1) |
          ({{(WORD_WIDTH-1){1'b0}}, w_sdi_s} << r_dwidth);
      else
        r_shreg <= {r_shreg[WORD_WIDTH-2:0], w_sdi_s};
    end
  end

  assign w_pop       = rec_ready_i & ~w_empty;
  assign w_accept    = ~w_full | w_pop;
  assign w_fifo_push = w_push_cyc & w_accept;
  assign w_drop      = w_push_cyc & ~w_accept;

  wfg_record_spi_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (~en_i),
    .push_i  (w_fifo_push),
    .wdata_i (r_shreg),
    .pop_i   (rec_ready_i),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign rec_valid_o = ~w_empty;
  assign rec_data_o  = w_empty ? '0 : w_head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_drop)     r_ovf <= 1'b1;
      else if (clr_i) r_ovf <= 1'b0;
      if (w_ferr)     r_ferr <= 1'b1;
      else if (clr_i) r_ferr <= 1'b0;
    end
  end

  assign overflow_o  = r_ovf;
  assign frame_err_o = r_ferr;

`ifdef WFG_RECORD_SPI_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (clr_i)
        r_frame_cnt <= {15'b0, w_fifo_push};
      else if (w_fifo_push)
        r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_drop && r_drop_cnt != 8'hFF)
        r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign frame_cnt_o = r_frame_cnt;
  assign drop_cnt_o  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_wfg_record_spi.sv
// tb_wfg_record_spi: scoreboard bench for wfg_record_spi.
// Frames are bit-banged on the pins; a monitor checks the stream.
module tb_wfg_record_spi;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, en_i, cs_pol_i, lsb_first_i;
  logic [4:0]  dwidth_i;
  logic        sclk_i, cs_i, sdi_i;
  logic [31:0] rec_data_o;
  logic        rec_valid_o, rec_ready_i;
  logic        overflow_o, frame_err_o, clr_i;
`ifdef WFG_RECORD_SPI_STATS_EN
  logic [15:0] frame_cnt_o;
  logic [7:0]  drop_cnt_o;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_pops   = 0;
  int          n_acc    = 0;
  logic [31:0] exp_q[$];
  bit          exp_ovf  = 0;
  bit          exp_ferr = 0;
  bit          rnd_rdy  = 0;

  always #5 clk = ~clk;

  wfg_record_spi #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
`ifdef WFG_RECORD_SPI_STATS_EN
    .frame_cnt_o (frame_cnt_o),
    .drop_cnt_o  (drop_cnt_o),
`endif
    .rst_n       (rst_n),
    .en_i        (en_i),
    .cs_pol_i    (cs_pol_i),
    .lsb_first_i (lsb_first_i),
    .dwidth_i    (dwidth_i),
    .sclk_i      (sclk_i),
    .cs_i        (cs_i),
    .sdi_i       (sdi_i),
    .rec_data_o  (rec_data_o),
    .rec_valid_o (rec_valid_o),
    .rec_ready_i (rec_ready_i),
    .overflow_o  (overflow_o),
    .frame_err_o (frame_err_o),
    .clr_i       (clr_i)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && rec_valid_o && rec_ready_i) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got %h expected none",
                 rec_data_o);
      end else begin
        chk("rec_data", rec_data_o, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_rdy) rec_ready_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic flush_model();
    n_acc -= exp_q.size();
    exp_q.delete();
  endtask

  task automatic chk_flags(input string nm);
    chk({nm, "_ovf"}, overflow_o, exp_ovf);
    chk({nm, "_ferr"}, frame_err_o, exp_ferr);
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    tick(1);
  endtask

  task automatic start_frame(input int dw, input bit lsb);
    dwidth_i    = 5'(dw);
    lsb_first_i = lsb;
    tick(2);
    cs_i = cs_pol_i;
    tick(4);
  endtask

  task automatic end_frame();
    sclk_i = 1'b0;
    tick(4);
    cs_i = ~cs_pol_i;
    tick(6);
  endtask

  // Reference: the received word is the sent word masked to nb bits.
  task automatic shift_bits(input logic [31:0] word, input int nb,
                            input bit lsb, input int from,
                            input int to, input bit complete,
                            input bit pop_at_push);
    logic [63:0] mask;
    int idx;
    mask = (64'd1 << nb) - 64'd1;
    for (int i = from; i < to; i++) begin
      idx    = lsb ? i : nb - 1 - i;
      sdi_i  = word[idx];
      sclk_i = 1'b0;
      tick(4);
      sclk_i = 1'b1;
      if (complete && i == nb - 1) begin
        if (exp_q.size() < DEPTH || pop_at_push) begin
          exp_q.push_back(word & mask[31:0]);
          n_acc++;
        end else begin
          exp_ovf = 1;
        end
      end
      if (complete && i == nb - 1 && pop_at_push) begin
        // Two sync stages, one detect cycle: ready lands in PUSH.
        tick(3);
        rec_ready_i = 1'b1;
        tick(1);
        rec_ready_i = 1'b0;
      end else begin
        tick(4);
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] word, input int dw,
                            input bit lsb, input bit pop_at_push);
    start_frame(dw, lsb);
    shift_bits(word, dw + 1, lsb, 0, dw + 1, 1, pop_at_push);
    end_frame();
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      tick(1);
      k++;
    end
    if (exp_q.size() != 0)
      chk({nm, "_drain_timeout"}, exp_q.size(), 0);
    tick(3);
    chk({nm, "_empty"}, rec_valid_o, 1'b0);
  endtask

  initial begin
    int p0;
    rst_n = 0; en_i = 1; cs_pol_i = 0; lsb_first_i = 0;
    dwidth_i = 5'd31; sclk_i = 0; cs_i = 1; sdi_i = 0;
    rec_ready_i = 1; clr_i = 0;
    tick(4);
    rst_n = 1;
    tick(4);
    chk("rst_valid", rec_valid_o, 1'b0);
    chk("rst_data", rec_data_o, 32'h0);
    chk_flags("rst");

    send_frame(32'h00006206, 31, 0, 0);
    send_frame(32'h0000B509, 31, 0, 0);
    wait_drain("basic");
    chk_flags("basic");

    send_frame(32'h00039DFA, 17, 1, 0);
    wait_drain("lsb18");

    start_frame(31, 0);
    shift_bits(32'hA5A5_5A5A, 32, 0, 0, 10, 0, 0);
    end_frame();
    exp_ferr = 1;
    chk_flags("early");
    chk("early_fifo", rec_valid_o, 1'b0);
    send_frame(32'h0000FFFD, 31, 0, 0);
    wait_drain("after_early");
    pulse_clr();
    exp_ferr = 0;
    chk_flags("clr_ferr");

    rec_ready_i = 0;
    for (int i = 0; i < DEPTH + 1; i++)
      send_frame($urandom, 31, 0, 0);
    chk_flags("ovf");
    chk("ovf_valid", rec_valid_o, 1'b1);
    pulse_clr();
    exp_ovf = 0;
    chk_flags("clr_ovf");

    send_frame($urandom, 31, 0, 1);
    chk_flags("full_pop");
    p0 = n_pops;
    rec_ready_i = 1;
    wait_drain("full_pop");
    chk("full_pop_occupancy", n_pops - p0, DEPTH);

    rec_ready_i = 0;
    send_frame($urandom, 31, 0, 0);
    chk("dis_pre_valid", rec_valid_o, 1'b1);
    start_frame(31, 0);
    shift_bits(32'h1234_5678, 32, 0, 0, 16, 0, 0);
    en_i = 0;
    tick(2);
    flush_model();
    chk("dis_valid", rec_valid_o, 1'b0);
    chk_flags("dis");
    en_i = 1;
    tick(2);
    shift_bits(32'h1234_5678, 32, 0, 16, 32, 0, 0);
    end_frame();
    chk("reen_no_word", rec_valid_o, 1'b0);
    rec_ready_i = 1;
    send_frame(32'hCAFE_0042, 31, 0, 0);
    wait_drain("reen");

    rec_ready_i = 0;
    send_frame($urandom, 31, 0, 0);
    start_frame(31, 0);
    shift_bits(32'hFFFF_FFFF, 32, 0, 0, 5, 0, 0);
    end_frame();
    exp_ferr = 1;
    chk_flags("pre_rst");
    start_frame(31, 0);
    shift_bits(32'h0F0F_0F0F, 32, 0, 0, 8, 0, 0);
    rst_n = 0;
    tick(1);
    flush_model();
    exp_ferr = 0;
    exp_ovf  = 0;
    chk("mrst_valid", rec_valid_o, 1'b0);
    chk("mrst_data", rec_data_o, 32'h0);
    chk_flags("mrst");
    cs_i = ~cs_pol_i;
    sclk_i = 0;
    tick(2);
    rst_n = 1;
    tick(6);
    rec_ready_i = 1;

    rnd_rdy = 1;
    for (int g = 0; g < 12; g++) begin
      cs_pol_i = 1'($urandom_range(0, 1));
      cs_i     = ~cs_pol_i;
      tick(4);
      for (int f = 0; f < int'($urandom_range(1, 3)); f++)
        send_frame($urandom, int'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), 0);
      wait_drain("rand");
      chk_flags("rand");
    end
    rnd_rdy = 0;
    rec_ready_i = 1;
    tick(4);
    chk("pop_count", n_pops, n_acc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
